// File: rtl/aes_pkg.sv
// aes_pkg: state encoding, round constants and GF(2^8)
// helpers shared by the AES-128 inverse cipher core.
package aes_pkg;

  localparam int AES_NR   = 10;
  localparam int RK_IDX_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // entry 0 sits in the top byte
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // coefficients used here never exceed 4 bits
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [3:0] c
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] b
  );
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return INV_SBOX_TBL[idx +: 8];
  endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// aes_inv_mix_column: InvMixColumns on one 32-bit column,
// row 0 in bits [31:24]. Purely combinational.
module aes_inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  assign o_col[31:24] = gmul(w_a0, 4'he) ^ gmul(w_a1, 4'hb)
                      ^ gmul(w_a2, 4'hd) ^ gmul(w_a3, 4'h9);
  assign o_col[23:16] = gmul(w_a0, 4'h9) ^ gmul(w_a1, 4'he)
                      ^ gmul(w_a2, 4'hb) ^ gmul(w_a3, 4'hd);
  assign o_col[15:8]  = gmul(w_a0, 4'hd) ^ gmul(w_a1, 4'h9)
                      ^ gmul(w_a2, 4'he) ^ gmul(w_a3, 4'hb);
  assign o_col[7:0]   = gmul(w_a0, 4'hb) ^ gmul(w_a1, 4'hd)
                      ^ gmul(w_a2, 4'h9) ^ gmul(w_a3, 4'he);

endmodule

// File: rtl/aes_inv_cipher_core.sv
// aes_inv_cipher_core: iterative AES-128 decryption, one round
// per clock. AES_INV_BACK2BACK_EN lets DONE accept the next block.
module aes_inv_cipher_core
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NR         = AES_NR
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_ct0,
  input  logic [DATA_WIDTH-1:0] in_ct1,
  input  logic [DATA_WIDTH-1:0] in_ct2,
  input  logic [DATA_WIDTH-1:0] in_ct3,
  output logic [RK_IDX_W-1:0]   out_rk_idx,
  input  logic [127:0]          in_rk,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pt0,
  output logic [DATA_WIDTH-1:0] out_pt1,
  output logic [DATA_WIDTH-1:0] out_pt2,
  output logic [DATA_WIDTH-1:0] out_pt3
);

  if (DATA_WIDTH != 32) begin : g_dw_err
    $error("aes_inv_cipher_core: DATA_WIDTH must be 32");
  end

  localparam logic [RK_IDX_W-1:0] LAST_RK  = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] FIRST_R  = RK_IDX_W'(NR - 1);
  localparam logic [RK_IDX_W-1:0] ONE_R    = RK_IDX_W'(1);

  logic [1:0]          r_state;
  logic [RK_IDX_W-1:0] r_round;
  logic [127:0]        r_st;

  logic [127:0] w_ct, w_load, w_isr, w_isb, w_ark, w_imc;
  logic         w_is_round, w_is_final, w_is_done;
  logic         w_rdy_done, w_accept;

  assign w_ct   = {in_ct0, in_ct1, in_ct2, in_ct3};
  assign w_load = w_ct ^ in_rk;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar k = 0; k < 4; k++) begin : g_row
      localparam int SRC = (c - k + 4) % 4;
      assign w_isr[127-32*c-8*k -: 8] =
        r_st[127-32*SRC-8*k -: 8];
      assign w_isb[127-32*c-8*k -: 8] =
        inv_sbox(w_isr[127-32*c-8*k -: 8]);
    end
    aes_inv_mix_column u_imc (
      .i_col (w_ark[127-32*c -: 32]),
      .o_col (w_imc[127-32*c -: 32])
    );
  end

  assign w_ark = w_isb ^ in_rk;

  assign w_is_round = (r_state == S_ROUND);
  assign w_is_final = (r_state == S_FINAL);
  assign w_is_done  = (r_state == S_DONE);

`ifdef AES_INV_BACK2BACK_EN
  assign w_rdy_done = out_ready;
`else
  assign w_rdy_done = 1'b0;
`endif

  assign in_ready = rst_n & ((r_state == S_IDLE)
                  | (w_is_done & w_rdy_done));
  assign w_accept = in_valid & in_ready;

  assign out_valid = w_is_done;
  assign out_pt0   = r_st[127:96];
  assign out_pt1   = r_st[95:64];
  assign out_pt2   = r_st[63:32];
  assign out_pt3   = r_st[31:0];

  // round-key index requested from the key store
  always_comb begin
    out_rk_idx = LAST_RK;
    unique case (1'b1)
      w_is_round: out_rk_idx = r_round;
      w_is_final: out_rk_idx = '0;
      default:    out_rk_idx = LAST_RK;
    endcase
  end

  // FSM, round counter and state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_round <= '0;
      r_st    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_st    <= w_load;
            r_round <= FIRST_R;
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_st    <= w_imc;
          r_round <= r_round - ONE_R;
          if (r_round == ONE_R) r_state <= S_FINAL;
        end
        S_FINAL: begin
          r_st    <= w_ark;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            if (w_accept) begin
              r_st    <= w_load;
              r_round <= FIRST_R;
              r_state <= S_ROUND;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// tb_aes_inv_cipher_core: known-answer vectors, stall, busy,
// reset and round-key sequence checks for the inverse core.
module tb_aes_inv_cipher_core;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_bus;
  logic [3:0]   out_rk_idx;
  logic [127:0] in_rk;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  pt0, pt1, pt2, pt3;
  logic [127:0] pt;

  logic [127:0] rk [0:10];
  logic         bad_en;
  logic [3:0]   bad_idx;

  int n_pass = 0;
  int n_tot  = 0;

  aes_inv_cipher_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ct0     (ct_bus[127:96]),
    .in_ct1     (ct_bus[95:64]),
    .in_ct2     (ct_bus[63:32]),
    .in_ct3     (ct_bus[31:0]),
    .out_rk_idx (out_rk_idx),
    .in_rk      (in_rk),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pt0    (pt0),
    .out_pt1    (pt1),
    .out_pt2    (pt2),
    .out_pt3    (pt3)
  );

  assign pt = {pt0, pt1, pt2, pt3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external key store, optionally corrupting one index
  always_comb begin
    in_rk = '0;
    if (out_rk_idx <= 4'd10) in_rk = rk[out_rk_idx];
    if (bad_en && out_rk_idx == bad_idx)
      in_rk = in_rk ^ 128'h1;
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic load_keys(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]),
             sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_ne(input string nm,
                        input logic [127:0] act,
                        input logic [127:0] bad);
    n_tot++;
    if (act !== bad) n_pass++;
    else $display("FAIL %s: got %h want any other value",
                  nm, act);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    string        nm;
  } vec_t;

  vec_t vec [3];

  task automatic wait_ready(input string nm);
    int to;
    to = 0;
    while (!in_ready && to < 40) begin
      @(negedge clk);
      to++;
    end
    chk({nm, "/accept"}, {127'd0, in_ready}, 128'd1);
  endtask

  task automatic run_block(input int v, input int stall,
                           input bit good, input string nm);
    logic [43:0]  seq, exp_seq;
    logic [127:0] hold;
    int           n;
    bit           ok_v, ok_p, ok_r;
    load_keys(vec[v].key);
    out_ready = (stall == 0);
    ct_bus    = vec[v].ct;
    in_valid  = 1'b1;
    wait_ready(nm);
    seq = {40'd0, out_rk_idx};
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 30) begin
      seq = {seq[39:0], out_rk_idx};
      @(negedge clk);
      n++;
    end
    exp_seq = '0;
    for (int i = 0; i < 11; i++)
      exp_seq = {exp_seq[39:0], 4'(10 - i)};
    chk({nm, "/latency"}, 128'(n), 128'd11);
    chk({nm, "/rk_seq"}, 128'(seq), 128'(exp_seq));
    if (good) chk({nm, "/pt"}, pt, vec[v].pt);
    else chk_ne({nm, "/pt_corrupt"}, pt, vec[v].pt);
    if (stall > 0) begin
      hold = pt;
      ok_v = 1; ok_p = 1; ok_r = 1;
      for (int s = 0; s < stall; s++) begin
        if (!out_valid) ok_v = 0;
        if (pt !== hold) ok_p = 0;
        if (in_ready) ok_r = 0;
        @(negedge clk);
      end
      chk({nm, "/stall_valid"}, 128'(ok_v), 128'd1);
      chk({nm, "/stall_pt"}, 128'(ok_p), 128'd1);
      chk({nm, "/stall_rdy"}, 128'(ok_r), 128'd0 + 1);
      chk({nm, "/stall_held"}, 128'(out_valid), 128'd1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({nm, "/handshake"}, 128'(out_valid), 128'd0);
  endtask

  int  to, n, pulses, t, t1, g1, g2, tl, bad;
  bit  busy_rdy, seen, drop, done_rdy;

  initial begin : main
    vec[0] = '{128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               128'h00112233445566778899aabbccddeeff,
               "fips_c1"};
    vec[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32,
               128'h3243f6a8885a308d313198a2e0370734,
               "fips_b"};
    vec[2] = '{128'h0,
               128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
               128'h0,
               "zero_key"};
    load_keys(vec[0].key);
    bad_en    = 1'b0;
    bad_idx   = 4'd5;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ct_bus    = '0;
    rst_n     = 1'b1;
    #3 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/in_ready", 128'(in_ready), 128'd0);
    chk("rst/out_valid", 128'(out_valid), 128'd0);
    chk("rst/out_pt", pt, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst/ready_after", 128'(in_ready), 128'd1);
    chk("rst/rk_idx", 128'(out_rk_idx), 128'd10);

    for (int v = 0; v < 3; v++) run_block(v, 0, 1, vec[v].nm);

    run_block(0, 20, 1, "stall");

    bad_en = 1'b1;
    run_block(0, 0, 0, "badkey5");
    bad_en = 1'b0;

    // second block offered while the first is in flight
    load_keys(vec[0].key);
    out_ready = 1'b1;
    ct_bus    = vec[0].ct;
    in_valid  = 1'b1;
    wait_ready("busyA");
    @(negedge clk);
    ct_bus   = vec[1].ct;
    busy_rdy = 0;
    n = 1;
    while (!out_valid && n < 30) begin
      if (in_ready) busy_rdy = 1;
      @(negedge clk);
      n++;
    end
    chk("busy/in_ready", 128'(busy_rdy), 128'd0);
    chk("busy/ptA", pt, vec[0].pt);
    done_rdy = in_ready;
`ifdef AES_INV_BACK2BACK_EN
    chk("busy/done_ready", 128'(done_rdy), 128'd1);
`else
    chk("busy/done_ready", 128'(done_rdy), 128'd0);
`endif
    load_keys(vec[1].key);
    n = 0;
    while (n < 40) begin
      if (in_valid && in_ready) begin
        @(negedge clk);
        in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      n++;
      if (out_valid && !in_valid) break;
    end
    chk("busy/B_out", 128'(out_valid), 128'd1);
    chk("busy/ptB", pt, vec[1].pt);
    @(negedge clk);
    in_valid = 1'b0;

    // reset pulled in the middle of a block
    load_keys(vec[0].key);
    ct_bus   = vec[0].ct;
    in_valid = 1'b1;
    wait_ready("rst_mid");
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_rk_idx != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid/round5", 128'(out_rk_idx), 128'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid/pt_now", pt, 128'd0);
    chk("rst_mid/rdy_now", 128'(in_ready), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid/ready", 128'(in_ready), 128'd1);
    chk("rst_mid/valid", 128'(out_valid), 128'd0);
    chk("rst_mid/pt", pt, 128'd0);
    chk("rst_mid/idx", 128'(out_rk_idx), 128'd10);
    seen = 0;
    repeat (15) begin
      if (out_valid) seen = 1;
      @(negedge clk);
    end
    chk("rst_mid/no_stale", 128'(seen), 128'd0);
    run_block(0, 0, 1, "post_rst");

`ifdef AES_INV_BACK2BACK_EN
    load_keys(vec[0].key);
    out_ready = 1'b1;
    ct_bus    = vec[0].ct;
    in_valid  = 1'b1;
    wait_ready("b2b");
    t = 0; pulses = 0; t1 = 0; g1 = 0; g2 = 0;
    tl = 0; bad = 0; drop = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      t++;
      if (drop) begin
        in_valid = 1'b0;
        drop = 0;
      end
      if (out_valid) begin
        pulses++;
        if (pt !== vec[0].pt) bad++;
        if (pulses == 1) t1 = t;
        if (pulses == 2) begin
          g1 = t - tl;
          drop = 1;
        end
        if (pulses == 3) g2 = t - tl;
        tl = t;
      end
    end
    in_valid = 1'b0;
    chk("b2b/pulses", 128'(pulses), 128'd3);
    chk("b2b/lat", 128'(t1), 128'd11);
    chk("b2b/gap1", 128'(g1), 128'd11);
    chk("b2b/gap2", 128'(g2), 128'd11);
    chk("b2b/pt", 128'(bad), 128'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
